sd_clk_ctrl: RTL and testbench

//  Converts a requested SD card clock frequency (Hz) into a half-period divisor using the shared
//  32-bit sequential divider (driven over the div_* ports), then generates sd_clk from clk.
//  New divisors are applied glitch-free, only at a falling-edge boundary. Sits between the

---
 rtl/sd_clk_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_sd_clk_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_clk_ctrl.sv
// sd_clk_ctrl: SD card clock generator with frequency-to-divisor conversion.
// A requested sd_clk frequency is converted into a half-period divisor,
// ceil(CLK_HZ / (2 * f)), saturated to [1, 2^DIV_W-1]. The division runs on
// the shared 32-bit sequential divider through the div_* ports. High requests
// that need a divisor of 1 skip the divider.
// A new divisor takes effect only where sd_clk falls, or immediately while
// sd_clk is parked low, so no phase is ever shortened.
// Optional feature: define SD_CLK_STROBE_EN to add the sd_clk_rise and
// sd_clk_fall edge strobe outputs.
module sd_clk_ctrl #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int DIV_W    = 16,
    parameter int INIT_DIV = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_freq,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic             sd_clk_en,
    output logic [DIV_W-1:0] cur_div,
    output logic             sd_clk,
`ifdef SD_CLK_STROBE_EN
    output logic             sd_clk_rise,
    output logic             sd_clk_fall,
`endif
    output logic             div_start,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    input  logic [31:0]      div_d,
    input  logic             div_ok
);

    typedef enum logic [1:0] {IDLE, CHECK, CALC, APPLY} state_t;

    localparam logic [32:0]      CLK33    = 33'(CLK_HZ);
    localparam logic [31:0]      CLK32    = 32'(CLK_HZ);
    localparam logic [31:0]      SAT32    = 32'((64'd1 << DIV_W) - 64'd1);
    localparam logic [DIV_W-1:0] SAT_DIV  = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] ONE_DIV  = DIV_W'(1);
    localparam logic [DIV_W-1:0] INIT_VAL = DIV_W'(INIT_DIV);

    state_t state;
    state_t state_next;

    logic             ready_armed;
    logic [31:0]      freq;
    logic [32:0]      two_f;
    logic [DIV_W-1:0] pend;
    logic [DIV_W-1:0] phase_cnt;
    logic [DIV_W-1:0] div_m1;
    logic             busy_seen;
    logic             accept;
    logic             freq_zero;
    logic             bypass;
    logic             last_cnt;
    logic             fall_now;
    logic             rise_now;
    logic             parked;
    logic             calc_done;
    logic             apply_now;

    assign accept    = cfg_valid && cfg_ready;
    assign two_f     = {freq, 1'b0};
    assign freq_zero = (freq == 32'd0);
    assign bypass    = (two_f >= CLK33);
    assign div_m1    = cur_div - ONE_DIV;
    assign last_cnt  = (phase_cnt == div_m1);
    assign fall_now  = sd_clk && last_cnt;
    assign rise_now  = !sd_clk && sd_clk_en && last_cnt;
    assign parked    = !sd_clk && !sd_clk_en;
    assign calc_done = busy_seen && div_ok;
    assign apply_now = (state == APPLY) && (fall_now || parked);

    // Request sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: check the request, divide if needed, wait for a safe edge
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CHECK;
            CHECK: begin
                if (freq_zero) begin
                    state_next = IDLE;
                end else if (bypass) begin
                    state_next = APPLY;
                end else begin
                    state_next = CALC;
                end
            end
            CALC:    if (calc_done) state_next = APPLY;
            APPLY:   if (apply_now) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs; start is withdrawn as soon as the result is seen so the divider never reloads
    always_comb begin
        cfg_ready = (state == IDLE) && ready_armed;
        div_start = (state == CALC) && !calc_done;
    end

    // Request datapath: latch frequency, set up divider operands, capture and clamp the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_armed <= 1'b0;
            freq        <= 32'd0;
            div_a       <= 32'd0;
            div_b       <= 32'd0;
            busy_seen   <= 1'b0;
            pend        <= INIT_VAL;
            cur_div     <= INIT_VAL;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            ready_armed <= 1'b1;
            cfg_done    <= 1'b0;
            if (accept) begin
                freq    <= cfg_freq;
                cfg_err <= 1'b0;
            end
            case (state)
                CHECK: begin
                    if (freq_zero) begin
                        cfg_err  <= 1'b1;
                        cfg_done <= 1'b1;
                    end else if (bypass) begin
                        pend <= ONE_DIV;
                    end else begin
                        div_a     <= CLK32 + two_f[31:0] - 32'd1;
                        div_b     <= two_f[31:0];
                        busy_seen <= 1'b0;
                    end
                end
                CALC: begin
                    if (!div_ok) begin
                        busy_seen <= 1'b1;
                    end
                    if (calc_done) begin
                        if (div_d > SAT32) begin
                            pend <= SAT_DIV;
                        end else if (div_d[DIV_W-1:0] == '0) begin
                            pend <= ONE_DIV;
                        end else begin
                            pend <= div_d[DIV_W-1:0];
                        end
                    end
                end
                APPLY: begin
                    if (apply_now) begin
                        cur_div  <= pend;
                        cfg_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clock generator: each phase lasts cur_div cycles; high phases always finish before parking low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_clk    <= 1'b0;
            phase_cnt <= '0;
        end else if (sd_clk) begin
            if (last_cnt) begin
                sd_clk    <= 1'b0;
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + ONE_DIV;
            end
        end else if (!sd_clk_en) begin
            phase_cnt <= '0;
        end else if (last_cnt) begin
            sd_clk    <= 1'b1;
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + ONE_DIV;
        end
    end

`ifdef SD_CLK_STROBE_EN
    // Edge strobes aligned with the sd_clk register update; silent while parked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_clk_rise <= 1'b0;
            sd_clk_fall <= 1'b0;
        end else begin
            sd_clk_rise <= rise_now;
            sd_clk_fall <= fall_now;
        end
    end
`else
    // Without strobes the rise decode has no consumer; fold it away explicitly
    logic unused_rise;
    assign unused_rise = rise_now;
`endif

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// tb_sd_clk_ctrl: directed self-checking bench for sd_clk_ctrl.
// Includes a behavioural model of the shared sequential divider:
// it loads on start while idle, stays busy for 32 cycles, then presents
// the quotient with div_ok high.
module tb_sd_clk_ctrl;

    localparam int LIMIT = 1000;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_freq;
    logic        cfg_done;
    logic        cfg_err;
    logic        sd_clk_en;
    logic [15:0] cur_div;
    logic        sd_clk;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_d;
    logic        div_ok;
`ifdef SD_CLK_STROBE_EN
    logic        sd_clk_rise;
    logic        sd_clk_fall;
`endif

    int tests_run;
    int tests_failed;

    logic [31:0] dv_q;
    int          dv_cnt;

    sd_clk_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_freq   (cfg_freq),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .sd_clk_en  (sd_clk_en),
        .cur_div    (cur_div),
        .sd_clk     (sd_clk),
`ifdef SD_CLK_STROBE_EN
        .sd_clk_rise(sd_clk_rise),
        .sd_clk_fall(sd_clk_fall),
`endif
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_d      (div_d),
        .div_ok     (div_ok)
    );

    // System clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider model: 32 busy cycles after a start accepted while idle
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            div_ok <= 1'b1;
            div_d  <= 32'd0;
            dv_cnt <= 0;
            dv_q   <= 32'd0;
        end else if (div_ok && div_start) begin
            div_ok <= 1'b0;
            dv_cnt <= 31;
            dv_q   <= (div_b == 32'd0) ? 32'hFFFF_FFFF : div_a / div_b;
        end else if (!div_ok) begin
            if (dv_cnt == 0) begin
                div_ok <= 1'b1;
                div_d  <= dv_q;
            end else begin
                dv_cnt <= dv_cnt - 1;
            end
        end
    end

    // Drive one request cycle; returns at the negedge after the accepting edge
    task automatic send_req(input logic [31:0] f);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_freq  = f;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Measure one full high phase and the following low phase in clk cycles
    task automatic measure_phases(output int hi, output int lo, output bit timed_out);
        int n;
        n = 0;
        hi = 0;
        lo = 0;
        while (sd_clk !== 1'b0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        while (sd_clk !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        while (sd_clk === 1'b1 && hi < LIMIT) begin
            hi++;
            @(negedge clk);
        end
        while (sd_clk === 1'b0 && lo < LIMIT) begin
            lo++;
            @(negedge clk);
        end
        timed_out = (n >= LIMIT) || (hi >= LIMIT) || (lo >= LIMIT);
    endtask

    task automatic test_reset;
        cfg_valid = 1'b0;
        cfg_freq  = 32'd0;
        sd_clk_en = 1'b1;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (cfg_ready !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
            $display("[TB] FAIL reset_handshake: ready=%b done=%b err=%b, want 0 0 0", cfg_ready, cfg_done, cfg_err);
            tests_failed++;
        end
        tests_run++;
        if (cur_div !== 16'd63 || sd_clk !== 1'b0) begin
            $display("[TB] FAIL reset_clock: cur_div=%0d sd_clk=%b, want 63 0", cur_div, sd_clk);
            tests_failed++;
        end
        tests_run++;
        if (div_start !== 1'b0 || div_a !== 32'd0 || div_b !== 32'd0) begin
            $display("[TB] FAIL reset_divider: start=%b a=%0d b=%0d, want 0 0 0", div_start, div_a, div_b);
            tests_failed++;
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cfg_ready !== 1'b1) begin
            $display("[TB] FAIL ready_after_reset: got %b want 1", cfg_ready);
            tests_failed++;
        end
    endtask

    task automatic test_default_clock;
        int hi, lo;
        bit to;
        measure_phases(hi, lo, to);
        tests_run++;
        if (to || hi != 63 || lo != 63) begin
            $display("[TB] FAIL default_period: high=%0d low=%0d timeout=%b, want 63 63 0", hi, lo, to);
            tests_failed++;
        end
    endtask

    task automatic test_divider_400k;
        int starts, dones;
        bit bad_ab;
        starts = 0;
        dones  = 0;
        bad_ab = 1'b0;
        send_req(32'd400_000);
        tests_run++;
        if (cfg_ready !== 1'b0) begin
            $display("[TB] FAIL ready_busy: got %b want 0", cfg_ready);
            tests_failed++;
        end
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 1 && (div_a !== 32'd50_799_999 || div_b !== 32'd800_000)) bad_ab = 1'b1;
            if (div_start === 1'b1) starts++;
            if (cfg_done === 1'b1) dones++;
            if (i == 5) begin
                cfg_valid = 1'b1;
                cfg_freq  = 32'd25_000_000;
            end
            if (i == 6) cfg_valid = 1'b0;
        end
        tests_run++;
        if (bad_ab) begin
            $display("[TB] FAIL div_operands_400k: a=%0d b=%0d, want 50799999 800000", div_a, div_b);
            tests_failed++;
        end
        tests_run++;
        if (starts != 33) begin
            $display("[TB] FAIL div_start_cycles: got %0d want 33", starts);
            tests_failed++;
        end
        tests_run++;
        if (dones != 1 || cur_div !== 16'd63 || cfg_err !== 1'b0) begin
            $display("[TB] FAIL apply_400k: done=%0d cur_div=%0d err=%b, want 1 63 0", dones, cur_div, cfg_err);
            tests_failed++;
        end
    endtask

    task automatic test_bypass_25m;
        int starts, dones, hi, lo;
        bit to;
        starts = 0;
        dones  = 0;
        send_req(32'd25_000_000);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (div_start === 1'b1) starts++;
            if (cfg_done === 1'b1) dones++;
        end
        tests_run++;
        if (starts != 0 || dones != 1 || cur_div !== 16'd1) begin
            $display("[TB] FAIL bypass_25m: starts=%0d done=%0d cur_div=%0d, want 0 1 1", starts, dones, cur_div);
            tests_failed++;
        end
        measure_phases(hi, lo, to);
        tests_run++;
        if (to || hi != 1 || lo != 1) begin
            $display("[TB] FAIL bypass_period: high=%0d low=%0d timeout=%b, want 1 1 0", hi, lo, to);
            tests_failed++;
        end
`ifdef SD_CLK_STROBE_EN
        begin
            int rises, falls;
            rises = 0;
            falls = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (sd_clk_rise === 1'b1) rises++;
                if (sd_clk_fall === 1'b1) falls++;
            end
            tests_run++;
            if (rises != 2 || falls != 2) begin
                $display("[TB] FAIL strobes_running: rise=%0d fall=%0d, want 2 2", rises, falls);
                tests_failed++;
            end
        end
`endif
    endtask

    task automatic test_mid_high_change;
        int dones, hi, lo, hi2, n;
        dones = 0;
        send_req(32'd400_000);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 1 || cur_div !== 16'd63) begin
            $display("[TB] FAIL back_to_63: done=%0d cur_div=%0d, want 1 63", dones, cur_div);
            tests_failed++;
        end
        dones = 0;
        n = 0;
        while (sd_clk !== 1'b0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        while (sd_clk !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        lo = 0;
        hi2 = 0;
        while (sd_clk === 1'b1 && hi < LIMIT) begin
            hi++;
            if (hi == 10) begin
                cfg_valid = 1'b1;
                cfg_freq  = 32'd100_000;
            end
            if (hi == 11) cfg_valid = 1'b0;
            @(negedge clk);
            if (cfg_done === 1'b1) dones++;
        end
        while (sd_clk === 1'b0 && lo < LIMIT) begin
            lo++;
            @(negedge clk);
            if (cfg_done === 1'b1) dones++;
        end
        while (sd_clk === 1'b1 && hi2 < LIMIT) begin
            hi2++;
            @(negedge clk);
        end
        tests_run++;
        if (n >= LIMIT || hi != 63 || lo != 250 || hi2 != 250) begin
            $display("[TB] FAIL change_63_to_250: high=%0d low=%0d high2=%0d, want 63 250 250", hi, lo, hi2);
            tests_failed++;
        end
        tests_run++;
        if (dones != 1 || cur_div !== 16'd250) begin
            $display("[TB] FAIL apply_250: done=%0d cur_div=%0d, want 1 250", dones, cur_div);
            tests_failed++;
        end
    endtask

    task automatic test_park;
        int hi, highs, n, strobes;
        n = 0;
        while (sd_clk !== 1'b0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        while (sd_clk !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        while (sd_clk === 1'b1 && hi < LIMIT) begin
            hi++;
            if (hi == 5) sd_clk_en = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (n >= LIMIT || hi != 250) begin
            $display("[TB] FAIL park_high_completes: high=%0d, want 250", hi);
            tests_failed++;
        end
        highs = 0;
        strobes = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sd_clk !== 1'b0) highs++;
`ifdef SD_CLK_STROBE_EN
            if (sd_clk_rise !== 1'b0 || sd_clk_fall !== 1'b0) strobes++;
`endif
        end
        tests_run++;
        if (highs != 0 || strobes != 0) begin
            $display("[TB] FAIL park_held_low: high_samples=%0d strobes=%0d, want 0 0", highs, strobes);
            tests_failed++;
        end
    endtask

    task automatic test_saturate_and_zero;
        int dones, n;
        bit err_cleared;
        dones = 0;
        send_req(32'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 1 || cur_div !== 16'd65535 || div_a !== 32'd50_000_001 || div_b !== 32'd2) begin
            $display("[TB] FAIL saturate_1hz: done=%0d cur_div=%0d a=%0d b=%0d, want 1 65535 50000001 2",
                     dones, cur_div, div_a, div_b);
            tests_failed++;
        end
        dones = 0;
        send_req(32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 1 || cfg_err !== 1'b1 || cur_div !== 16'd65535 || cfg_ready !== 1'b1) begin
            $display("[TB] FAIL zero_freq: done=%0d err=%b cur_div=%0d ready=%b, want 1 1 65535 1",
                     dones, cfg_err, cur_div, cfg_ready);
            tests_failed++;
        end
        dones = 0;
        send_req(32'd400_000);
        err_cleared = (cfg_err === 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) dones++;
        end
        tests_run++;
        if (!err_cleared || dones != 1 || cur_div !== 16'd63 || cfg_err !== 1'b0) begin
            $display("[TB] FAIL err_clear_and_63: cleared=%b done=%0d cur_div=%0d err=%b, want 1 1 63 0",
                     err_cleared, dones, cur_div, cfg_err);
            tests_failed++;
        end
        @(negedge clk);
        sd_clk_en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sd_clk !== 1'b1 && n < LIMIT);
        tests_run++;
        if (n != 63) begin
            $display("[TB] FAIL reenable_delay: got %0d cycles want 63", n);
            tests_failed++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_default_clock();
        test_divider_400k();
        test_bypass_25m();
        test_mid_high_change();
        test_park();
        test_saturate_and_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
